// File: rtl/msb_read_requester.sv
`default_nettype none
// ============================================================================
// msb_read_requester: burst read initiator for the multi-stream buffer, with a
// credit-limited request issue path and a response FIFO toward downstream.
// Optional request/stall counters are built when MSB_RDREQ_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
module msb_read_requester #(
    parameter int ST_WIDTH   = 4,
    parameter int CL_WIDTH   = 4,
    parameter int OF_WIDTH   = 3,
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk1x,
    input  logic                  reset_n,
    input  logic                  cmd_v,
    output logic                  cmd_r,
    input  logic [ST_WIDTH-1:0]   cmd_st,
    input  logic [CL_WIDTH-1:0]   cmd_cl,
    input  logic [OF_WIDTH-1:0]   cmd_of,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  o_v,
    input  logic                  i_r,
    output logic [ST_WIDTH-1:0]   o_ra_st,
    output logic [CL_WIDTH-1:0]   o_ra_cl,
    output logic [OF_WIDTH-1:0]   o_ra_of,
    input  logic                  i_v,
    output logic                  o_r,
    input  logic [DATA_WIDTH-1:0] i_rd,
    output logic                  o_dv,
    input  logic                  i_dr,
    output logic [DATA_WIDTH-1:0] o_dd,
    output logic                  o_dlast,
    output logic                  o_done,
    output logic                  o_err,
    output logic [31:0]           o_stat_req,
    output logic [31:0]           o_stat_stall
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]   c_DEPTH   = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);
    localparam logic [LEN_WIDTH-1:0] c_LEN_ONE = LEN_WIDTH'(1);
    localparam logic [CL_WIDTH-1:0]  c_CL_ONE  = CL_WIDTH'(1);
    localparam logic [OF_WIDTH-1:0]  c_OF_TWO  = OF_WIDTH'(2);
    localparam logic [OF_WIDTH-1:0]  c_OF_MASK = ~OF_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    logic [ST_WIDTH-1:0]    r_st;
    logic [CL_WIDTH-1:0]    r_cl;
    logic [OF_WIDTH-1:0]    r_of;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_remaining;
    logic [LEN_WIDTH-1:0]   r_popped;
    logic [c_CNT_W-1:0]     r_reserved;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_PTR_W-1:0]     r_wptr;
    logic [c_PTR_W-1:0]     r_rptr;
    logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic                   r_done;
    logic                   r_err;

    logic w_full, w_empty, w_issue, w_pop, w_wr, w_last, w_of_wrap;

    assign w_full    = (r_count == c_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_issue   = o_v && i_r;
    assign w_pop     = o_dv && i_dr;
    assign w_wr      = i_v && !w_full;
    assign w_of_wrap = &r_of[OF_WIDTH-1:1];
    // Current beat is the last when it would bring the popped count up to len.
    assign w_last    = (({1'b0, r_popped} + {{LEN_WIDTH{1'b0}}, 1'b1}) == {1'b0, r_len});

    assign cmd_r   = (r_state == S_IDLE);
    assign o_v     = (r_state == S_ISSUE) && (r_reserved < c_DEPTH);
    assign o_ra_st = r_st;
    assign o_ra_cl = r_cl;
    assign o_ra_of = r_of;
    assign o_r     = !w_full;
    assign o_dv    = !w_empty;
    assign o_dd    = o_dv ? r_mem[r_rptr] : '0;
    assign o_dlast = o_dv && w_last;
    assign o_done  = r_done;
    assign o_err   = r_err;

    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_st        <= '0;
            r_cl        <= '0;
            r_of        <= '0;
            r_len       <= '0;
            r_remaining <= '0;
            r_popped    <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) begin
                r_popped <= r_popped + c_LEN_ONE;
            end
            case (r_state)
                S_IDLE: begin
                    if (cmd_v) begin
                        r_st        <= cmd_st;
                        r_cl        <= cmd_cl;
                        r_of        <= cmd_of & c_OF_MASK;
                        r_len       <= cmd_len;
                        r_remaining <= cmd_len;
                        r_popped    <= '0;
                        if (cmd_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_remaining <= r_remaining - c_LEN_ONE;
                        if (w_of_wrap) begin
                            r_of <= '0;
                            r_cl <= r_cl + c_CL_ONE;
                        end else begin
                            r_of <= r_of + c_OF_TWO;
                        end
                        if (r_remaining == c_LEN_ONE) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Credits: a request holds a slot until its beat leaves downstream.
    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            r_reserved <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_err      <= 1'b0;
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_reserved <= r_reserved + c_CNT_ONE;
                2'b01:   r_reserved <= r_reserved - c_CNT_ONE;
                default: r_reserved <= r_reserved;
            endcase
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_wr) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            if (i_v && w_full) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk1x) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_rd;
        end
    end

`ifdef MSB_RDREQ_STATS_EN
    logic [31:0] r_stat_req;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_req   <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_issue) begin
                r_stat_req <= r_stat_req + 32'd1;
            end
            if (o_v && !i_r) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign o_stat_req   = r_stat_req;
    assign o_stat_stall = r_stat_stall;
`else
    assign o_stat_req   = '0;
    assign o_stat_stall = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_msb_read_requester.sv
`default_nettype none
// ============================================================================
// tb_msb_read_requester: scoreboard bench with a 2-cycle buffer model.
// Revision: 1.0
// ============================================================================
module tb_msb_read_requester;
    logic         clk1x;
    logic         reset_n;
    logic         cmd_v;
    logic         cmd_r;
    logic [3:0]   cmd_st;
    logic [3:0]   cmd_cl;
    logic [2:0]   cmd_of;
    logic [7:0]   cmd_len;
    logic         o_v;
    logic         i_r;
    logic [3:0]   o_ra_st;
    logic [3:0]   o_ra_cl;
    logic [2:0]   o_ra_of;
    logic         i_v;
    logic         o_r;
    logic [127:0] i_rd;
    logic         o_dv;
    logic         i_dr;
    logic [127:0] o_dd;
    logic         o_dlast;
    logic         o_done;
    logic         o_err;
    logic [31:0]  o_stat_req;
    logic [31:0]  o_stat_stall;

    msb_read_requester dut (
        .clk1x(clk1x), .reset_n(reset_n),
        .cmd_v(cmd_v), .cmd_r(cmd_r), .cmd_st(cmd_st), .cmd_cl(cmd_cl),
        .cmd_of(cmd_of), .cmd_len(cmd_len),
        .o_v(o_v), .i_r(i_r), .o_ra_st(o_ra_st), .o_ra_cl(o_ra_cl), .o_ra_of(o_ra_of),
        .i_v(i_v), .o_r(o_r), .i_rd(i_rd),
        .o_dv(o_dv), .i_dr(i_dr), .o_dd(o_dd), .o_dlast(o_dlast),
        .o_done(o_done), .o_err(o_err),
        .o_stat_req(o_stat_req), .o_stat_stall(o_stat_stall)
    );

    typedef struct {
        logic [127:0] d;
        int           rdy;
    } resp_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_req_hs = 0;
    int n_done = 0;
    int last_pop_cyc = -1;
    int done_cyc = -1;
    int mseq = 0;
    int eseq = 0;

    logic [10:0]  exp_req [$];
    logic [128:0] exp_beat [$];
    resp_t        pend [$];
    logic [10:0]  er;
    logic [128:0] eb;

    logic         bm_v = 1'b0;
    logic [127:0] bm_d = '0;
    logic         inj_v = 1'b0;
    logic [127:0] inj_d = '0;

    assign i_v  = bm_v | inj_v;
    assign i_rd = inj_v ? inj_d : bm_d;

    initial clk1x = 1'b0;
    always #5 clk1x = ~clk1x;

    function automatic logic [127:0] mkdata(input logic [3:0] st, input logic [3:0] cl,
                                            input logic [2:0] of, input int seq);
        logic [31:0] s;
        s = seq;
        return {s, 20'hBEEF0, st, cl, 1'b0, of, ~{32'h0, s}};
    endfunction

    // Buffer model: returns each accepted request's beat two cycles later.
    always @(posedge clk1x) begin
        cyc = cyc + 1;
        #1;
        if (!reset_n) begin
            pend.delete();
            bm_v = 1'b0;
        end else if (pend.size() > 0 && pend[0].rdy <= cyc) begin
            bm_d = pend[0].d;
            pend.pop_front();
            bm_v = 1'b1;
        end else begin
            bm_v = 1'b0;
        end
    end

    // Scoreboard monitor for requests, beats and completion pulses.
    always @(negedge clk1x) begin
        if (reset_n) begin
            if (o_v && i_r) begin
                n_req_hs++;
                pend.push_back('{d: mkdata(o_ra_st, o_ra_cl, o_ra_of, mseq), rdy: cyc + 2});
                mseq++;
                n_chk++;
                if (exp_req.size() == 0) begin
                    n_fail++;
                    $display("FAIL req_extra: got addr %h, expected no request", {o_ra_st, o_ra_cl, o_ra_of});
                end else begin
                    er = exp_req.pop_front();
                    if ({o_ra_st, o_ra_cl, o_ra_of} !== er) begin
                        n_fail++;
                        $display("FAIL req_addr: got %h, expected %h", {o_ra_st, o_ra_cl, o_ra_of}, er);
                    end
                end
            end
            if (o_dv && i_dr) begin
                n_chk++;
                if (exp_beat.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_extra: got %h, expected no beat", {o_dlast, o_dd});
                end else begin
                    eb = exp_beat.pop_front();
                    if ({o_dlast, o_dd} !== eb) begin
                        n_fail++;
                        $display("FAIL beat_data: got %h, expected %h", {o_dlast, o_dd}, eb);
                    end
                end
                if (o_dlast) last_pop_cyc = cyc;
            end
            if (o_done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        cmd_v = 1'b0; cmd_st = '0; cmd_cl = '0; cmd_of = '0; cmd_len = '0;
        i_r = 1'b1; i_dr = 1'b1; inj_v = 1'b0;
        repeat (3) @(posedge clk1x);
        #1;
        exp_req.delete();
        exp_beat.delete();
        mseq = 0;
        eseq = 0;
        reset_n = 1'b1;
    endtask

    task automatic send_cmd(input logic [3:0] st, input logic [3:0] cl,
                            input logic [2:0] of, input logic [7:0] len);
        logic [3:0] c;
        logic [2:0] o;
        @(posedge clk1x);
        #1;
        cmd_v = 1'b1; cmd_st = st; cmd_cl = cl; cmd_of = of; cmd_len = len;
        c = cl;
        o = of & 3'b110;
        for (int i = 0; i < int'(len); i++) begin
            exp_req.push_back({st, c, o});
            exp_beat.push_back({(i == int'(len) - 1), mkdata(st, c, o, eseq)});
            eseq++;
            if (o == 3'd6) begin
                o = 3'd0;
                c = c + 4'd1;
            end else begin
                o = o + 3'd2;
            end
        end
        @(posedge clk1x);
        #1;
        cmd_v = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk1x);
            #1;
            if (n_done > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk1x);
        n_chk++;
        if ({cmd_r, o_r, o_v, o_dv, o_dlast, o_done, o_err} !== 7'b1100000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, expected 1100000", {cmd_r, o_r, o_v, o_dv, o_dlast, o_done, o_err});
        end
        n_chk++;
        if ({o_ra_st, o_ra_cl, o_ra_of} !== 11'h0 || o_dd !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got addr %h dd %h, expected 0", {o_ra_st, o_ra_cl, o_ra_of}, o_dd);
        end
        n_chk++;
        if ({o_stat_req, o_stat_stall} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_stats: got %h, expected 0", {o_stat_req, o_stat_stall});
        end
    endtask

    task automatic test_basic();
        int  base;
        bit  ok;
        logic [4:0] ovs;
        i_r = 1'b1; i_dr = 1'b1;
        base = n_done;
        send_cmd(4'd1, 4'd4, 3'd0, 8'd4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk1x);
            ovs[k] = o_v;
            if (k == 0) begin
                n_chk++;
                if (cmd_r !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_cmd_r_busy: got %b, expected 0", cmd_r);
                end
            end
        end
        n_chk++;
        if (ovs !== 5'b01111) begin
            n_fail++;
            $display("FAIL basic_issue_cycles: got %b, expected 01111", ovs);
        end
        wait_done(base, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_done_timeout: got no done, expected done");
        end
        n_chk++;
        if (done_cyc - last_pop_cyc !== 1) begin
            n_fail++;
            $display("FAIL basic_done_latency: got %0d, expected 1", done_cyc - last_pop_cyc);
        end
        @(negedge clk1x);
        n_chk++;
        if ({o_done, cmd_r} !== 2'b01 || n_done - base !== 1) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got done=%b cmd_r=%b pulses=%0d, expected 0 1 1", o_done, cmd_r, n_done - base);
        end
        n_chk++;
        if (exp_req.size() + exp_beat.size() !== 0) begin
            n_fail++;
            $display("FAIL basic_leftover: got %0d, expected 0", exp_req.size() + exp_beat.size());
        end
    endtask

    task automatic test_wrap();
        int base;
        bit ok;
        base = n_done;
        send_cmd(4'd2, 4'd15, 3'd7, 8'd2);
        wait_done(base, ok);
        n_chk++;
        if (!ok || done_cyc - last_pop_cyc !== 1) begin
            n_fail++;
            $display("FAIL wrap_done: got ok=%b latency=%0d, expected 1 1", ok, done_cyc - last_pop_cyc);
        end
        n_chk++;
        if (exp_req.size() + exp_beat.size() !== 0) begin
            n_fail++;
            $display("FAIL wrap_leftover: got %0d, expected 0", exp_req.size() + exp_beat.size());
        end
    endtask

    task automatic test_len0();
        int base;
        base = n_done;
        send_cmd(4'd5, 4'd3, 3'd2, 8'd0);
        @(negedge clk1x);
        n_chk++;
        if ({o_v, o_done, cmd_r} !== 3'b011) begin
            n_fail++;
            $display("FAIL len0_first: got %b, expected 011", {o_v, o_done, cmd_r});
        end
        @(negedge clk1x);
        n_chk++;
        if ({o_v, o_done, cmd_r} !== 3'b001 || n_done - base !== 1) begin
            n_fail++;
            $display("FAIL len0_second: got %b pulses=%0d, expected 001 1", {o_v, o_done, cmd_r}, n_done - base);
        end
    endtask

    task automatic test_backpressure();
        int base;
        int base_req;
        bit ok;
        base = n_done;
        base_req = n_req_hs;
        i_dr = 1'b0;
        send_cmd(4'd3, 4'd2, 3'd0, 8'd12);
        repeat (25) @(negedge clk1x);
        n_chk++;
        if (n_req_hs - base_req !== 8 || o_v !== 1'b0 || o_r !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_credit_limit: got reqs=%0d o_v=%b o_r=%b, expected 8 0 0", n_req_hs - base_req, o_v, o_r);
        end
        n_chk++;
        if (exp_beat.size() == 0 || o_dv !== 1'b1 || {o_dlast, o_dd} !== exp_beat[0]) begin
            n_fail++;
            $display("FAIL bp_hold_head: got dv=%b beat=%h, expected head of queue", o_dv, {o_dlast, o_dd});
        end
        @(posedge clk1x);
        #1;
        i_dr = 1'b1;
        wait_done(base, ok);
        n_chk++;
        if (!ok || n_req_hs - base_req !== 12) begin
            n_fail++;
            $display("FAIL bp_resume: got ok=%b reqs=%0d, expected 1 12", ok, n_req_hs - base_req);
        end
        n_chk++;
        if (exp_req.size() + exp_beat.size() !== 0) begin
            n_fail++;
            $display("FAIL bp_leftover: got %0d, expected 0", exp_req.size() + exp_beat.size());
        end
    endtask

    task automatic test_stall_stats();
        int base;
        int issued;
        int stalls;
        bit ok;
        do_reset();
        base = n_done;
        issued = 0;
        stalls = 0;
        i_r = 1'b0;
        send_cmd(4'd4, 4'd6, 3'd2, 8'd3);
        for (int k = 0; k < 40 && issued < 3; k++) begin
            @(negedge clk1x);
            if (o_v && !i_r) begin
                stalls++;
                n_chk++;
                if (exp_req.size() == 0 || {o_ra_st, o_ra_cl, o_ra_of} !== exp_req[0]) begin
                    n_fail++;
                    $display("FAIL stall_addr_hold: got %h, expected pending request address", {o_ra_st, o_ra_cl, o_ra_of});
                end
            end
            if (o_v && i_r) issued++;
            @(posedge clk1x);
            #1;
            i_r = ~i_r;
        end
        i_r = 1'b1;
        wait_done(base, ok);
        n_chk++;
        if (!ok || issued !== 3 || stalls !== 3) begin
            n_fail++;
            $display("FAIL stall_sequence: got ok=%b issued=%0d stalls=%0d, expected 1 3 3", ok, issued, stalls);
        end
`ifdef MSB_RDREQ_STATS_EN
        n_chk++;
        if (o_stat_req !== 32'd3 || o_stat_stall !== 32'(stalls)) begin
            n_fail++;
            $display("FAIL stats_counts: got req=%0d stall=%0d, expected 3 %0d", o_stat_req, o_stat_stall, stalls);
        end
`else
        n_chk++;
        if ({o_stat_req, o_stat_stall} !== 64'h0) begin
            n_fail++;
            $display("FAIL stats_tied: got %h, expected 0", {o_stat_req, o_stat_stall});
        end
`endif
    endtask

    task automatic test_err_reset();
        int base;
        i_r = 1'b1;
        i_dr = 1'b0;
        send_cmd(4'd6, 4'd1, 3'd4, 8'd12);
        repeat (25) @(negedge clk1x);
        n_chk++;
        if (o_r !== 1'b0 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_full_before: got o_r=%b o_err=%b, expected 0 0", o_r, o_err);
        end
        @(posedge clk1x);
        #1;
        inj_d = {4{32'hBAD0BAD0}};
        inj_v = 1'b1;
        @(posedge clk1x);
        #1;
        inj_v = 1'b0;
        @(negedge clk1x);
        n_chk++;
        if (o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got %b, expected 1", o_err);
        end
        repeat (5) @(negedge clk1x);
        n_chk++;
        if (o_err !== 1'b1 || exp_beat.size() == 0 || {o_dlast, o_dd} !== exp_beat[0]) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b beat=%h, expected 1 and unchanged head", o_err, {o_dlast, o_dd});
        end
        @(negedge clk1x);
        #2;
        reset_n = 1'b0;
        #1;
        n_chk++;
        if ({o_err, o_v, cmd_r, o_dv, o_r} !== 5'b00101) begin
            n_fail++;
            $display("FAIL async_reset: got %b, expected 00101", {o_err, o_v, cmd_r, o_dv, o_r});
        end
        repeat (2) @(posedge clk1x);
        #1;
        exp_req.delete();
        exp_beat.delete();
        mseq = 0;
        eseq = 0;
        i_dr = 1'b1;
        reset_n = 1'b1;
        base = n_done;
        repeat (10) @(negedge clk1x);
        n_chk++;
        if (n_done !== base || o_err !== 1'b0 || cmd_r !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_no_done: got pulses=%0d err=%b cmd_r=%b, expected 0 0 1", n_done - base, o_err, cmd_r);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_len0();
        test_backpressure();
        test_stall_stats();
        test_err_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
